program_loader: RTL and testbench

- Boot-time loader that sits directly upstream of the pipeline top level. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- It drives the program-memory load port (TB_LOAD_PROGRAM_*) and the data-memory load port (TB_LOAD_DATA_*), then releases the core by asserting START.
- It replaces testbench-driven loading, so the same image format can be used in simulation and on an FPGA (e.g. a UART byte source).

---
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte stream to program/data memory load ports, then START
module program_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CLR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [7:0]        IN_DATA,
    output logic              TB_LOAD_PROGRAM_CTRL,
    output logic [ADDR_W-1:0] TB_LOAD_PROGRAM_ADDR,
    output logic [31:0]       TB_LOAD_PROGRAM_DATA,
    output logic              TB_LOAD_DATA_CTRL,
    output logic [ADDR_W-1:0] TB_LOAD_DATA_ADDR,
    output logic [31:0]       TB_LOAD_DATA_DATA,
    output logic              START,
    output logic              BUSY,
    output logic              ERR
);

    typedef enum logic [2:0] {S_HDR, S_PROG, S_DATA, S_RUN, S_ERROR} state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    logic [1:0]  lane;
    logic [15:0] pcnt;
    logic [15:0] dcnt;
    logic [15:0] widx;
    logic [23:0] asm_word;

    logic        accept;
    logic [31:0] word_full;
    logic [15:0] dcnt_full;
    logic        hdr_bad;
    logic        last_word;

    assign BUSY      = (state == S_HDR) || (state == S_PROG) || (state == S_DATA);
    assign IN_READY  = BUSY && !CLR;
    assign accept    = IN_VALID && IN_READY;
    assign word_full = {IN_DATA, asm_word};
    // The 4th header byte is judged before it lands in dcnt.
    assign dcnt_full = {IN_DATA, dcnt[7:0]};
    assign hdr_bad   = (pcnt == 16'd0) || ({1'b0, pcnt} > MAX_W) || ({1'b0, dcnt_full} > MAX_W);
    assign last_word = (widx == (((state == S_PROG) ? pcnt : dcnt) - 16'd1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state                <= S_HDR;
            lane                 <= 2'd0;
            pcnt                 <= 16'd0;
            dcnt                 <= 16'd0;
            widx                 <= 16'd0;
            asm_word             <= 24'd0;
            TB_LOAD_PROGRAM_CTRL <= 1'b0;
            TB_LOAD_PROGRAM_ADDR <= '0;
            TB_LOAD_PROGRAM_DATA <= 32'd0;
            TB_LOAD_DATA_CTRL    <= 1'b0;
            TB_LOAD_DATA_ADDR    <= '0;
            TB_LOAD_DATA_DATA    <= 32'd0;
            START                <= 1'b0;
            ERR                  <= 1'b0;
        end else if (CLR) begin
            state                <= S_HDR;
            lane                 <= 2'd0;
            pcnt                 <= 16'd0;
            dcnt                 <= 16'd0;
            widx                 <= 16'd0;
            asm_word             <= 24'd0;
            TB_LOAD_PROGRAM_CTRL <= 1'b0;
            TB_LOAD_DATA_CTRL    <= 1'b0;
            START                <= 1'b0;
            ERR                  <= 1'b0;
        end else begin
            TB_LOAD_PROGRAM_CTRL <= 1'b0;
            TB_LOAD_DATA_CTRL    <= 1'b0;
            // Entering RUN happens on the edge that launches the final strobe,
            // so START rises one edge later, after that strobe cycle.
            if (state == S_RUN)
                START <= 1'b1;
            if (accept) begin
                lane <= lane + 2'd1;
                case (state)
                    S_HDR: begin
                        case (lane)
                            2'd0: pcnt[7:0]  <= IN_DATA;
                            2'd1: pcnt[15:8] <= IN_DATA;
                            2'd2: dcnt[7:0]  <= IN_DATA;
                            default: begin
                                dcnt[15:8] <= IN_DATA;
                                state      <= hdr_bad ? S_ERROR : S_PROG;
                                ERR        <= hdr_bad;
                            end
                        endcase
                    end
                    S_PROG, S_DATA: begin
                        case (lane)
                            2'd0: asm_word[7:0]   <= IN_DATA;
                            2'd1: asm_word[15:8]  <= IN_DATA;
                            2'd2: asm_word[23:16] <= IN_DATA;
                            default: begin
                                if (state == S_PROG) begin
                                    TB_LOAD_PROGRAM_CTRL <= 1'b1;
                                    TB_LOAD_PROGRAM_ADDR <= widx[ADDR_W-1:0];
                                    TB_LOAD_PROGRAM_DATA <= word_full;
                                end else begin
                                    TB_LOAD_DATA_CTRL <= 1'b1;
                                    TB_LOAD_DATA_ADDR <= widx[ADDR_W-1:0];
                                    TB_LOAD_DATA_DATA <= word_full;
                                end
                                if (last_word) begin
                                    widx <= 16'd0;
                                    if (state == S_PROG && dcnt != 16'd0)
                                        state <= S_DATA;
                                    else
                                        state <= S_RUN;
                                end else begin
                                    widx <= widx + 16'd1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven and scoreboard bench for program_loader
module tb_program_loader;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        CLR = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  IN_DATA = 8'd0;
    logic        PC, DC;
    logic [9:0]  PA, DA;
    logic [31:0] PD, DD;
    logic        START, BUSY, ERR;

    program_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .CLK(CLK), .RSTn(RSTn), .CLR(CLR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .TB_LOAD_PROGRAM_CTRL(PC), .TB_LOAD_PROGRAM_ADDR(PA), .TB_LOAD_PROGRAM_DATA(PD),
        .TB_LOAD_DATA_CTRL(DC), .TB_LOAD_DATA_ADDR(DA), .TB_LOAD_DATA_DATA(DD),
        .START(START), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pcnt;
        logic [15:0] dcnt;
        logic [31:0] w0, w1, w2;
        bit          throttle;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          port;
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   acc_cyc = 0;
    int   first_acc = 0;
    int   nacc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        ncyc++;
        if (RSTn && (PC || DC)) begin
            chk("strobe_excl", 32'(PC) + 32'(DC), 32'd1);
            chk("strobe_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("strobe_port", 32'(DC), 32'(e.port));
                chk("strobe_addr", 32'(e.port ? DA : PA), 32'(e.addr));
                chk("strobe_data", e.port ? DD : PD, e.data);
                chk("strobe_cycle", ncyc, e.cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        bit ok = 0;
        if (throttle) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            @(posedge CLK);
        end
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            IN_DATA  = b;
            #1;
            ok = IN_READY;
            @(posedge CLK);
        end
        acc_cyc = ncyc;
        if (ok) begin
            if (nacc == 0) first_acc = acc_cyc;
            nacc++;
        end
        chk("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input bit port, input int idx, input logic [31:0] w, input bit throttle);
        exp_t e;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], throttle);
        e.port = port;
        e.addr = idx[9:0];
        e.data = w;
        e.cyc  = acc_cyc + 1;
        q.push_back(e);
    endtask

    task automatic send_hdr(input logic [15:0] p, input logic [15:0] d, input bit throttle);
        nacc = 0;
        send_byte(p[7:0], throttle);
        send_byte(p[15:8], throttle);
        send_byte(d[7:0], throttle);
        send_byte(d[15:8], throttle);
    endtask

    task automatic do_clr();
        @(negedge CLK);
        CLR      = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'hA5;
        #1;
        chk("clr_ready_low", 32'(IN_READY), 32'd0);
        @(negedge CLK);
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk("clr_busy", 32'(BUSY), 32'd1);
        chk("clr_start", 32'(START), 32'd0);
        chk("clr_err", 32'(ERR), 32'd0);
        chk("clr_ready", 32'(IN_READY), 32'd1);
    endtask

    task automatic finish_check(input bit exp_err);
        @(negedge CLK);
        #1;
        if (!exp_err) chk("start_in_strobe_cycle", 32'(START), 32'd0);
        @(negedge CLK);
        #1;
        chk("end_start", 32'(START), 32'(!exp_err));
        chk("end_err", 32'(ERR), 32'(exp_err));
        chk("end_ready", 32'(IN_READY), 32'd0);
        chk("end_busy", 32'(BUSY), 32'd0);
        chk("end_queue_empty", 32'(q.size()), 32'd0);
        IN_VALID = 1'b0;
    endtask

    function automatic logic [31:0] word_val(input int k, input vec_t v);
        if (k == 0) return v.w0;
        if (k == 1) return v.w1;
        if (k == 2) return v.w2;
        return $urandom;
    endfunction

    vec_t vecs[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'd1,    16'd0,    32'h00000013, 32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1] = '{16'd2,    16'd1,    32'h00500093, 32'h00A00113, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{16'd2,    16'd1,    32'h00500093, 32'h00A00113, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[3] = '{16'd0,    16'd0,    32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
        vecs[4] = '{16'h0401, 16'd0,    32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
        vecs[5] = '{16'd1,    16'h0400, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 1'b0};
        vecs[6] = '{16'd1,    16'h0401, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};

        #12;
        chk("rst_ready", 32'(IN_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd1);
        chk("rst_start", 32'(START), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_ctrl", 32'({PC, DC}), 32'd0);
        chk("rst_addr", 32'({PA, DA}), 32'd0);
        chk("rst_pdata", PD, 32'd0);
        chk("rst_ddata", DD, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int v = 0; v < 7; v++) begin
            int k = 0;
            do_clr();
            send_hdr(vecs[v].pcnt, vecs[v].dcnt, vecs[v].throttle);
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < int'(vecs[v].pcnt); i++) begin
                    send_word(1'b0, i, word_val(k, vecs[v]), vecs[v].throttle);
                    k++;
                end
                for (int i = 0; i < int'(vecs[v].dcnt); i++) begin
                    send_word(1'b1, i, word_val(k, vecs[v]), vecs[v].throttle);
                    k++;
                end
                if (!vecs[v].throttle)
                    chk("no_bubbles", acc_cyc - first_acc, nacc - 1);
                if (v == 1) chk("full_image_bytes", nacc, 16);
            end
            finish_check(vecs[v].exp_err);
        end

        // CLR in the middle of program word 1 must drop the partial word.
        do_clr();
        send_hdr(16'd2, 16'd0, 1'b0);
        send_word(1'b0, 0, 32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        do_clr();
        send_hdr(16'd1, 16'd0, 1'b0);
        send_word(1'b0, 0, 32'h00000013, 1'b0);
        finish_check(1'b0);

        // Asynchronous reset between edges while in DATA.
        do_clr();
        send_hdr(16'd1, 16'd2, 1'b0);
        send_word(1'b0, 0, 32'hA0A0A0A0, 1'b0);
        send_word(1'b1, 0, 32'hB1B1B1B1, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_ctrl", 32'({PC, DC}), 32'd0);
        chk("arst_addr", 32'({PA, DA}), 32'd0);
        chk("arst_pdata", PD, 32'd0);
        chk("arst_ddata", DD, 32'd0);
        chk("arst_start", 32'(START), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        chk("arst_ready", 32'(IN_READY), 32'd1);
        send_hdr(16'd1, 16'd1, 1'b0);
        chk("arst_start_hdr", 32'(START), 32'd0);
        send_word(1'b0, 0, 32'h0000006F, 1'b0);
        send_word(1'b1, 0, 32'h87654321, 1'b0);
        finish_check(1'b0);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
